// File: rtl/nibble_serial_sub16_pkg.sv
// Shared definitions for the nibble-serial 16-bit subtractor:
// FSM state encoding, default geometry and a slice-count helper.
package nibble_serial_sub16_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of SLICE-bit slices needed to cover a WIDTH-bit operand.
    function automatic int slice_count(input int width, input int slice);
        return width / slice;
    endfunction

endpackage

// File: rtl/nibble_serial_sub16_sub_slice4.sv
// Combinational SLICE-bit slice of a subtractor: {cout, s} = a + ~b + cin.
// Built as a per-bit ripple so the slice is a plain chain of full adders.
module sub_slice4
    import nibble_serial_sub16_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout
);

    logic [SLICE:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
            // Full adder on a and the inverted subtrahend bit.
            assign s[gi]     = a[gi] ^ ~b[gi] ^ c[gi];
            assign c[gi + 1] = (a[gi] & ~b[gi]) | (a[gi] & c[gi]) | (~b[gi] & c[gi]);
        end
    endgenerate

    assign cout = c[SLICE];

endmodule

// File: rtl/nibble_serial_sub16.sv
// Multi-cycle subtractor d = a - b, one SLICE-bit slice per clock.
// Operands are captured on acceptance; the borrow chain is carried between
// slices in a flop (stored as a true carry, so carry = ~borrow).
// When a new operand is accepted in the same cycle the previous result is
// handed off, slice 0 of the new operation is computed straight from the
// input ports on that edge, which gives an NSL-cycle back-to-back cadence.
module nibble_serial_sub16
    import nibble_serial_sub16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf
);

    localparam int NSL = slice_count(WIDTH, SLICE);
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    generate
        if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_geometry
            $error("nibble_serial_sub16: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [SLICE-1:0] op_a;
    logic [SLICE-1:0] op_b;
    logic             op_cin;
    logic [SLICE-1:0] sum;
    logic             cout;
    logic             accept;

    // Ready while idle, or while a result is being handed off this cycle; never during reset.
    assign in_ready = ~rst & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    // Slice operand select: live inputs for the overlapped first slice, else the indexed operand registers.
    always_comb begin
        op_a   = a_reg[SLICE*int'(cnt) +: SLICE];
        op_b   = b_reg[SLICE*int'(cnt) +: SLICE];
        op_cin = carry;
        if (state == ST_DONE) begin
            op_a   = a[SLICE-1:0];
            op_b   = b[SLICE-1:0];
            op_cin = 1'b1;
        end
    end

    sub_slice4 #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .s    (sum),
        .cout (cout)
    );

    // Control FSM, slice counter, carry flop and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            carry     <= 1'b1;
            a_reg     <= '0;
            b_reg     <= '0;
            out_valid <= 1'b0;
            d         <= '0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= 1'b1;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    d[SLICE*int'(cnt) +: SLICE] <= sum;
                    carry <= cout;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        borrow    <= ~cout;
                        ovf       <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (sum[SLICE-1] ^ a_reg[WIDTH-1]);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                        if (in_valid) begin
                            a_reg           <= a;
                            b_reg           <= b;
                            d[SLICE-1:0]    <= sum;
                            carry           <= cout;
                            if (NSL == 1) begin
                                // Single-slice geometry: the overlapped slice is the whole result.
                                out_valid <= 1'b1;
                                borrow    <= ~cout;
                                ovf       <= (a[WIDTH-1] ^ b[WIDTH-1]) & (sum[SLICE-1] ^ a[WIDTH-1]);
                                state     <= ST_DONE;
                            end else begin
                                cnt   <= CW'(1);
                                state <= ST_BUSY;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
